tt_um_fsm_monitor: RTL and testbench

TT_UM_FSM_MONITOR -- requirements
Module: tt_um_fsm_monitor

---
 rtl/tt_fsm_pkg.sv | 46 ++++
 rtl/tt_um_fsm_monitor_if.sv | 28 ++
 rtl/tt_um_fsm_monitor_core.sv | 112 +++++++++++
 rtl/tt_um_fsm_monitor_seg7_hex.sv | 31 +++
 rtl/tt_um_fsm_monitor.sv | 33 +++
 tb/tb_tt_um_fsm_monitor.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/tt_fsm_pkg.sv
// Shared definitions for the tt_um_fsm sequencer and its monitor: tracker
// state encodings, the four LED status codes, and small lookup helpers.
package tt_fsm_pkg;

    // Tracker states; the encoding is exported on uio_out[7:5].
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_COUNT  = 3'b001,
        ST_WAIT   = 3'b010,
        ST_DONE   = 3'b011,
        ST_ERROR  = 3'b100,
        ST_RESYNC = 3'b101
    } tracker_state_t;

    // LED status codes driven by the sequencer.
    localparam logic [7:0] CODE_IDLE  = 8'd0;
    localparam logic [7:0] CODE_COUNT = 8'd10;
    localparam logic [7:0] CODE_WAIT  = 8'd5;
    localparam logic [7:0] CODE_DONE  = 8'd15;

    // Bidirectional pins: upper nibble is output, lower nibble is input.
    localparam logic [7:0] UIO_OE_VALUE = 8'b1111_0000;

    // LED code the sequencer shows while it sits in a given phase.
    function automatic logic [7:0] state_code(input tracker_state_t s);
        case (s)
            ST_IDLE:  state_code = CODE_IDLE;
            ST_COUNT: state_code = CODE_COUNT;
            ST_WAIT:  state_code = CODE_WAIT;
            ST_DONE:  state_code = CODE_DONE;
            default:  state_code = CODE_IDLE;
        endcase
    endfunction

    // The only phase a well-behaved sequencer may move to next.
    function automatic tracker_state_t legal_next(input tracker_state_t s);
        case (s)
            ST_IDLE:  legal_next = ST_COUNT;
            ST_COUNT: legal_next = ST_WAIT;
            ST_WAIT:  legal_next = ST_DONE;
            ST_DONE:  legal_next = ST_IDLE;
            default:  legal_next = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tt_um_fsm_monitor_if.sv
// Pin bundle of the Tiny Tapeout user tile: the dedicated inputs/outputs
// and the bidirectional bank. The tile wrapper (or a bench) is the master.
interface tt_um_fsm_monitor_if;
    import tt_fsm_pkg::*;

    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface

// File: rtl/tt_um_fsm_monitor_core.sv
// Monitor core: debounces the observed LED code, tracks the sequencer phase,
// flags illegal progressions, and counts completed cycles.
module tt_um_fsm_monitor_core
    import tt_fsm_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    tt_um_fsm_monitor_if.slave   bus
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

    logic [7:0]     cand;
    logic [7:0]     cnt;
    logic           accept;
    tracker_state_t state;
    tracker_state_t state_next;
    logic [3:0]     count;
    logic [3:0]     count_next;
    logic           cycle_done;
    logic           cycle_done_next;
    logic           clear_err;
    logic           clear_cnt;
    logic [6:0]     seg;
    logic           unused_uio_bits;

    assign clear_err       = bus.uio_in[0];
    assign clear_cnt       = bus.uio_in[1];
    assign unused_uio_bits = &{1'b0, bus.uio_in[7:2]};

    // Acceptance comes from registers only, so a code seen first at edge t
    // is acted on at edge t+STABLE_CYCLES and ui_in never reaches an output.
    assign accept = (cnt == STABLE_CNT);

    // Stability filter: restart the run length on any change, saturate otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand <= CODE_IDLE;
            cnt  <= STABLE_CNT;
        end else if (ena) begin
            if (bus.ui_in != cand) begin
                cand <= bus.ui_in;
                cnt  <= 8'd1;
            end else if (cnt != STABLE_CNT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Tracker state, cycle counter and the one-clock done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= 4'd0;
            cycle_done <= 1'b0;
        end else if (ena) begin
            state      <= state_next;
            count      <= count_next;
            cycle_done <= cycle_done_next;
        end else begin
            cycle_done <= 1'b0;
        end
    end

    // Next-state, done pulse and counter update; clear-count beats increment.
    always_comb begin
        state_next      = state;
        cycle_done_next = 1'b0;
        count_next      = count;
        case (state)
            ST_IDLE, ST_COUNT, ST_WAIT, ST_DONE: begin
                if (accept && (cand != state_code(state))) begin
                    if (cand == state_code(legal_next(state))) begin
                        state_next      = legal_next(state);
                        cycle_done_next = (state == ST_DONE);
                    end else begin
                        state_next = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                if (clear_err) begin
                    state_next = ST_RESYNC;
                end
            end
            ST_RESYNC: begin
                if (accept && (cand == CODE_IDLE)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (clear_cnt) begin
            count_next = 4'd0;
        end else if (cycle_done_next) begin
            count_next = count + 4'd1;
        end
    end

    seg7_hex u_seg7 (
        .digit    (count),
        .segments (seg)
    );

    assign bus.uo_out  = {(state == ST_ERROR), seg};
    assign bus.uio_out = {state, cycle_done, 4'b0000};
    assign bus.uio_oe  = UIO_OE_VALUE;

endmodule

// File: rtl/tt_um_fsm_monitor_seg7_hex.sv
// Hex digit to 7-segment pattern, segments {g,f,e,d,c,b,a}, active high.
module seg7_hex (
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    // Standard hex font lookup.
    always_comb begin
        segments = 7'h00;
        case (digit)
            4'h0: segments = 7'h3F;
            4'h1: segments = 7'h06;
            4'h2: segments = 7'h5B;
            4'h3: segments = 7'h4F;
            4'h4: segments = 7'h66;
            4'h5: segments = 7'h6D;
            4'h6: segments = 7'h7D;
            4'h7: segments = 7'h07;
            4'h8: segments = 7'h7F;
            4'h9: segments = 7'h6F;
            4'hA: segments = 7'h77;
            4'hB: segments = 7'h7C;
            4'hC: segments = 7'h39;
            4'hD: segments = 7'h5E;
            4'hE: segments = 7'h79;
            4'hF: segments = 7'h71;
            default: segments = 7'h00;
        endcase
    end

endmodule

// File: rtl/tt_um_fsm_monitor.sv
// Tiny Tapeout tile top: flat tile pins mapped onto the pin bundle that the
// monitor core consumes.
module tt_um_fsm_monitor #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    tt_um_fsm_monitor_if bus ();

    assign bus.ui_in  = ui_in;
    assign bus.uio_in = uio_in;
    assign uo_out     = bus.uo_out;
    assign uio_out    = bus.uio_out;
    assign uio_oe     = bus.uio_oe;

    tt_um_fsm_monitor_core #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

endmodule

// File: tb/tb_tt_um_fsm_monitor.sv
// Directed bench for tt_um_fsm_monitor with STABLE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_tt_um_fsm_monitor;

    logic clk;
    logic rst_n;
    logic ena;
    int   tests_run;
    int   fail_count;

    tt_um_fsm_monitor_if tb_bus ();

    tt_um_fsm_monitor #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (tb_bus.ui_in),
        .uo_out  (tb_bus.uo_out),
        .uio_in  (tb_bus.uio_in),
        .uio_out (tb_bus.uio_out),
        .uio_oe  (tb_bus.uio_oe)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hex font, written out independently of the design.
    function automatic logic [7:0] seg_of(input int n);
        logic [6:0] font [16];
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        seg_of = {1'b0, font[n % 16]};
    endfunction

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Present a code and let n rising edges pass.
    task automatic apply_code(input logic [7:0] code, input int n);
        tb_bus.ui_in = code;
        repeat (n) @(negedge clk);
    endtask

    // One full legal sequence from IDLE (code 0 accepted) back to IDLE.
    task automatic run_cycle();
        apply_code(8'd10, 4);
        apply_code(8'd5, 4);
        apply_code(8'd15, 4);
        apply_code(8'd0, 5);
    endtask

    initial begin
        tests_run     = 0;
        fail_count    = 0;
        rst_n         = 1'b1;
        ena           = 1'b1;
        tb_bus.ui_in  = 8'd0;
        tb_bus.uio_in = 8'd0;

        #3 rst_n = 1'b0;
        #1;
        check_output("reset_uo_out", tb_bus.uo_out, 8'h3F);
        check_output("reset_uio_out", tb_bus.uio_out, 8'h00);
        check_output("uio_oe", tb_bus.uio_oe, 8'hF0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full legal cycle 0,10,5,15,0.
        apply_code(8'd10, 4);
        check_output("idle_before_accept", tb_bus.uio_out, 8'h00);
        apply_code(8'd5, 1);
        check_output("count_state", tb_bus.uio_out, 8'h20);
        apply_code(8'd5, 3);
        apply_code(8'd15, 1);
        check_output("wait_state", tb_bus.uio_out, 8'h40);
        apply_code(8'd15, 3);
        apply_code(8'd0, 1);
        check_output("done_state", tb_bus.uio_out, 8'h60);
        apply_code(8'd0, 3);
        check_output("done_held", tb_bus.uio_out, 8'h60);
        apply_code(8'd0, 1);
        check_output("cycle_done_pulse", tb_bus.uio_out, 8'h10);
        check_output("count_one", tb_bus.uo_out, 8'h06);
        apply_code(8'd0, 1);
        check_output("pulse_one_clock", tb_bus.uio_out, 8'h00);

        // Glitch of code 3 for two clocks is filtered out.
        apply_code(8'd10, 4);
        apply_code(8'd3, 1);
        check_output("glitch_count_state", tb_bus.uio_out, 8'h20);
        apply_code(8'd3, 1);
        apply_code(8'd10, 6);
        check_output("glitch_ignored", tb_bus.uio_out, 8'h20);
        check_output("glitch_no_error", tb_bus.uo_out, 8'h06);
        apply_code(8'd5, 4);
        apply_code(8'd15, 4);
        apply_code(8'd0, 5);
        check_output("count_two", tb_bus.uo_out, 8'h5B);
        apply_code(8'd0, 1);

        // Clear-error outside ERROR does nothing.
        tb_bus.uio_in = 8'h01;
        apply_code(8'd0, 2);
        tb_bus.uio_in = 8'h00;
        check_output("clear_err_in_idle", tb_bus.uio_out, 8'h00);

        // Skipping from IDLE to WAIT is an error, and it sticks.
        apply_code(8'd5, 4);
        check_output("idle_before_error", tb_bus.uio_out, 8'h00);
        apply_code(8'd0, 1);
        check_output("error_state", tb_bus.uio_out, 8'h80);
        check_output("error_flag", tb_bus.uo_out, 8'hDB);
        apply_code(8'd0, 6);
        check_output("error_sticky", tb_bus.uio_out, 8'h80);

        // Clear error -> RESYNC, waits for an accepted 0.
        tb_bus.uio_in = 8'h01;
        apply_code(8'd10, 1);
        tb_bus.uio_in = 8'h00;
        check_output("resync_state", tb_bus.uio_out, 8'hA0);
        check_output("resync_flag_low", tb_bus.uo_out, 8'h5B);
        apply_code(8'd10, 6);
        check_output("resync_ignores", tb_bus.uio_out, 8'hA0);
        apply_code(8'd0, 4);
        check_output("resync_before_zero", tb_bus.uio_out, 8'hA0);
        apply_code(8'd0, 1);
        check_output("resync_to_idle", tb_bus.uio_out, 8'h00);

        // Clear count, then 16 cycles wrap the counter.
        tb_bus.uio_in = 8'h02;
        apply_code(8'd0, 1);
        tb_bus.uio_in = 8'h00;
        check_output("count_cleared", tb_bus.uo_out, 8'h3F);
        for (int i = 1; i <= 16; i++) begin
            run_cycle();
            check_output($sformatf("wrap_pulse_%0d", i), tb_bus.uio_out, 8'h10);
            check_output($sformatf("wrap_count_%0d", i), tb_bus.uo_out, seg_of(i));
        end

        // Clear count on the same edge as the 17th increment.
        apply_code(8'd10, 4);
        apply_code(8'd5, 4);
        apply_code(8'd15, 4);
        apply_code(8'd0, 4);
        tb_bus.uio_in = 8'h02;
        apply_code(8'd0, 1);
        tb_bus.uio_in = 8'h00;
        check_output("clear_wins_pulse", tb_bus.uio_out, 8'h10);
        check_output("clear_wins_count", tb_bus.uo_out, 8'h3F);

        // Count up to 1 so the reset has progress to discard.
        run_cycle();
        check_output("count_before_reset", tb_bus.uo_out, 8'h06);

        // Asynchronous reset in WAIT.
        apply_code(8'd10, 4);
        apply_code(8'd5, 4);
        apply_code(8'd15, 1);
        check_output("wait_before_reset", tb_bus.uio_out, 8'h40);
        #2 rst_n = 1'b0;
        #1;
        check_output("async_reset_uio_out", tb_bus.uio_out, 8'h00);
        check_output("async_reset_uo_out", tb_bus.uo_out, 8'h3F);
        tb_bus.ui_in = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // ena low freezes the filter and the tracker.
        apply_code(8'd10, 2);
        ena = 1'b0;
        apply_code(8'd10, 5);
        check_output("ena_freeze", tb_bus.uio_out, 8'h00);
        ena = 1'b1;
        apply_code(8'd10, 2);
        check_output("ena_resume_hold", tb_bus.uio_out, 8'h00);
        apply_code(8'd10, 1);
        check_output("ena_resume_accept", tb_bus.uio_out, 8'h20);

        // Illegal code from COUNT goes to ERROR.
        apply_code(8'hFF, 5);
        check_output("illegal_code_error", tb_bus.uo_out, 8'hBF);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
